// File: rtl/dds_sweep_ctrl_if.sv
// Config/control and DDS-drive bundle for the sweep sequencer.
// The slave side is the sequencer; the master side is the register block or driver.
interface dds_sweep_ctrl_if #(
   parameter int KW = 32,
   parameter int PW = 11,
   parameter int DW = 16
);
   logic          i_start;
   logic          i_abort;
   logic [KW-1:0] i_cfg_k_start;
   logic [KW-1:0] i_cfg_k_stop;
   logic [KW-1:0] i_cfg_k_step;
   logic [DW-1:0] i_cfg_dwell;
   logic [PW-1:0] i_cfg_phase;
   logic          i_cfg_mode;
   logic [KW-1:0] o_k_out;
   logic [PW-1:0] o_p_out;
   logic          o_k_update;
   logic          o_busy;
   logic          o_done;
   logic          o_cfg_err;

   modport slave (
      input  i_start, i_abort, i_cfg_k_start, i_cfg_k_stop, i_cfg_k_step,
             i_cfg_dwell, i_cfg_phase, i_cfg_mode,
      output o_k_out, o_p_out, o_k_update, o_busy, o_done, o_cfg_err
   );

   modport master (
      output i_start, i_abort, i_cfg_k_start, i_cfg_k_stop, i_cfg_k_step,
             i_cfg_dwell, i_cfg_phase, i_cfg_mode,
      input  o_k_out, o_p_out, o_k_update, o_busy, o_done, o_cfg_err
   );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer feeding the K/P inputs of the DDS core.
// Single-shot (up once, done) or triangle (up/down until abort), with a
// per-step dwell of cfg_dwell+1 cycles. All outputs are registered.
module dds_sweep_ctrl #(
   parameter int KW = 32,
   parameter int PW = 11,
   parameter int DW = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   dds_sweep_ctrl_if.slave     bus
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_UP = 2'd1, S_DOWN = 2'd2} state_t;

   state_t        r_state, w_state_nx;
   logic [DW-1:0] r_dwell, w_dwell_nx;
   logic [KW-1:0] r_k_start, w_k_start_nx;
   logic [KW-1:0] r_k_stop, w_k_stop_nx;
   logic [KW-1:0] r_k_step, w_k_step_nx;
   logic [DW-1:0] r_dwell_cfg, w_dwell_cfg_nx;
   logic          r_mode, w_mode_nx;
   logic [KW-1:0] r_k_out, w_k_out_nx;
   logic [PW-1:0] r_p_out, w_p_out_nx;
   logic          r_k_update, w_k_update_nx;
   logic          r_busy, w_busy_nx;
   logic          r_done, w_done_nx;
   logic          r_cfg_err, w_cfg_err_nx;

   logic          w_expire;
   logic          w_cfg_ok;
   logic [KW:0]   w_up_sum;
   logic [KW-1:0] w_up_k;
   logic [KW-1:0] w_dn_diff;
   logic [KW-1:0] w_dn_k;

   // Saturating step arithmetic: the up sum carries an extra bit so it can
   // never wrap; the down step compares the headroom above start with the
   // step so it never underflows (k_out is always >= start while sweeping).
   always_comb begin
      w_expire  = (r_dwell == '0);
      w_cfg_ok  = (bus.i_cfg_k_step != '0) && (bus.i_cfg_k_start <= bus.i_cfg_k_stop);
      w_up_sum  = {1'b0, r_k_out} + {1'b0, r_k_step};
      w_up_k    = (w_up_sum > {1'b0, r_k_stop}) ? r_k_stop : w_up_sum[KW-1:0];
      w_dn_diff = r_k_out - r_k_start;
      w_dn_k    = (w_dn_diff <= r_k_step) ? r_k_start : (r_k_out - r_k_step);
   end

   // Next-state and next-output logic; strobes default low every cycle.
   always_comb begin
      w_state_nx     = r_state;
      w_dwell_nx     = r_dwell;
      w_k_start_nx   = r_k_start;
      w_k_stop_nx    = r_k_stop;
      w_k_step_nx    = r_k_step;
      w_dwell_cfg_nx = r_dwell_cfg;
      w_mode_nx      = r_mode;
      w_k_out_nx     = r_k_out;
      w_p_out_nx     = r_p_out;
      w_k_update_nx  = 1'b0;
      w_busy_nx      = r_busy;
      w_done_nx      = 1'b0;
      w_cfg_err_nx   = 1'b0;

      if (bus.i_abort) begin
         w_state_nx = S_IDLE;
         w_busy_nx  = 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  if (w_cfg_ok) begin
                     w_k_start_nx   = bus.i_cfg_k_start;
                     w_k_stop_nx    = bus.i_cfg_k_stop;
                     w_k_step_nx    = bus.i_cfg_k_step;
                     w_dwell_cfg_nx = bus.i_cfg_dwell;
                     w_mode_nx      = bus.i_cfg_mode;
                     w_k_out_nx     = bus.i_cfg_k_start;
                     w_p_out_nx     = bus.i_cfg_phase;
                     w_dwell_nx     = bus.i_cfg_dwell;
                     w_k_update_nx  = 1'b1;
                     w_busy_nx      = 1'b1;
                     w_state_nx     = S_UP;
                  end else begin
                     w_cfg_err_nx = 1'b1;
                  end
               end
            end
            S_UP: begin
               if (!w_expire) begin
                  w_dwell_nx = r_dwell - 1'b1;
               end else if (r_k_out < r_k_stop) begin
                  w_k_out_nx    = w_up_k;
                  w_k_update_nx = 1'b1;
                  w_dwell_nx    = r_dwell_cfg;
               end else if (!r_mode) begin
                  w_state_nx = S_IDLE;
                  w_busy_nx  = 1'b0;
                  w_done_nx  = 1'b1;
               end else begin
                  w_state_nx    = S_DOWN;
                  w_k_out_nx    = w_dn_k;
                  w_k_update_nx = 1'b1;
                  w_dwell_nx    = r_dwell_cfg;
               end
            end
            S_DOWN: begin
               if (!w_expire) begin
                  w_dwell_nx = r_dwell - 1'b1;
               end else if (r_k_out > r_k_start) begin
                  w_k_out_nx    = w_dn_k;
                  w_k_update_nx = 1'b1;
                  w_dwell_nx    = r_dwell_cfg;
               end else begin
                  w_state_nx    = S_UP;
                  w_k_out_nx    = w_up_k;
                  w_k_update_nx = 1'b1;
                  w_dwell_nx    = r_dwell_cfg;
               end
            end
            default: begin
               w_state_nx = S_IDLE;
               w_busy_nx  = 1'b0;
            end
         endcase
      end
   end

   // State, captured config and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_dwell     <= '0;
         r_k_start   <= '0;
         r_k_stop    <= '0;
         r_k_step    <= '0;
         r_dwell_cfg <= '0;
         r_mode      <= 1'b0;
         r_k_out     <= '0;
         r_p_out     <= '0;
         r_k_update  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_dwell     <= w_dwell_nx;
         r_k_start   <= w_k_start_nx;
         r_k_stop    <= w_k_stop_nx;
         r_k_step    <= w_k_step_nx;
         r_dwell_cfg <= w_dwell_cfg_nx;
         r_mode      <= w_mode_nx;
         r_k_out     <= w_k_out_nx;
         r_p_out     <= w_p_out_nx;
         r_k_update  <= w_k_update_nx;
         r_busy      <= w_busy_nx;
         r_done      <= w_done_nx;
         r_cfg_err   <= w_cfg_err_nx;
      end
   end

   assign bus.o_k_out    = r_k_out;
   assign bus.o_p_out    = r_p_out;
   assign bus.o_k_update = r_k_update;
   assign bus.o_busy     = r_busy;
   assign bus.o_done     = r_done;
   assign bus.o_cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: single-shot, saturation, triangle,
// abort, invalid config, overflow edges, async reset and start+abort.
module tb_dds_sweep_ctrl;
   localparam int KW = 32;
   localparam int PW = 11;
   localparam int DW = 16;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   dds_sweep_ctrl_if #(.KW(KW), .PW(PW), .DW(DW)) bus ();

   dds_sweep_ctrl #(.KW(KW), .PW(PW), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input logic [KW-1:0] ks, input logic [KW-1:0] ke,
                          input logic [KW-1:0] st, input logic [DW-1:0] dw,
                          input logic [PW-1:0] ph, input logic md);
      bus.i_cfg_k_start = ks;
      bus.i_cfg_k_stop  = ke;
      bus.i_cfg_k_step  = st;
      bus.i_cfg_dwell   = dw;
      bus.i_cfg_phase   = ph;
      bus.i_cfg_mode    = md;
   endtask

   task automatic pulse_start();
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
   endtask

   initial begin
      logic [KW-1:0] tri_seq [7];
      logic [KW-1:0] ovf_seq [5];
      logic [KW-1:0] sat_seq [4];
      int            upd_cnt;

      checks   = 0;
      failures = 0;
      tri_seq  = '{32'd10, 32'd20, 32'd30, 32'd20, 32'd10, 32'd20, 32'd30};
      ovf_seq  = '{32'hFFFFFF00, 32'hFFFFFF80, 32'hFFFFFFFF, 32'hFFFFFF7F, 32'hFFFFFF00};
      sat_seq  = '{32'd0, 32'd100, 32'd200, 32'd250};

      rst_n       = 1'b0;
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      set_cfg('0, '0, '0, '0, '0, 1'b0);
      tick();
      tick();
      chk("rst_k_out", 64'(bus.o_k_out), 64'd0);
      chk("rst_p_out", 64'(bus.o_p_out), 64'd0);
      chk("rst_flags", {60'd0, bus.o_k_update, bus.o_busy, bus.o_done, bus.o_cfg_err}, 64'd0);
      rst_n = 1'b1;
      tick();

      // Single-shot, dwell 2: 100..400 each held 3 cycles, then done.
      set_cfg(32'd100, 32'd400, 32'd100, 16'd2, 11'h155, 1'b0);
      pulse_start();
      chk("ss_p_out", 64'(bus.o_p_out), 64'h155);
      upd_cnt = 0;
      for (int s = 0; s < 4; s++) begin
         for (int h = 0; h < 3; h++) begin
            chk($sformatf("ss_k_out_s%0d_h%0d", s, h), 64'(bus.o_k_out), 64'(100 * (s + 1)));
            chk($sformatf("ss_upd_s%0d_h%0d", s, h), 64'(bus.o_k_update), 64'(h == 0));
            chk($sformatf("ss_busy_s%0d_h%0d", s, h), {62'd0, bus.o_busy, bus.o_done}, 64'b10);
            if (bus.o_k_update) upd_cnt++;
            tick();
         end
      end
      chk("ss_upd_count", 64'(upd_cnt), 64'd4);
      chk("ss_done_pulse", {61'd0, bus.o_busy, bus.o_done, bus.o_k_update}, 64'b010);
      chk("ss_k_hold", 64'(bus.o_k_out), 64'd400);
      tick();
      chk("ss_done_low", 64'(bus.o_done), 64'd0);
      chk("ss_p_hold", 64'(bus.o_p_out), 64'h155);

      // Single-shot, dwell 0: last step saturates at stop.
      set_cfg(32'd0, 32'd250, 32'd100, 16'd0, 11'd7, 1'b0);
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("sat_k_out_%0d", i), 64'(bus.o_k_out), 64'(sat_seq[i]));
         chk($sformatf("sat_upd_%0d", i), 64'(bus.o_k_update), 64'd1);
         tick();
      end
      chk("sat_done", {62'd0, bus.o_busy, bus.o_done}, 64'b01);
      tick();

      // Triangle, dwell 0; a start with a bad config mid-sweep is ignored
      // and the live cfg change must not disturb the captured config.
      set_cfg(32'd10, 32'd30, 32'd10, 16'd0, 11'd0, 1'b1);
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("tri_k_out_%0d", i), 64'(bus.o_k_out), 64'(tri_seq[i]));
         chk($sformatf("tri_flags_%0d", i), {61'd0, bus.o_k_update, bus.o_busy, bus.o_done}, 64'b110);
         chk($sformatf("tri_err_%0d", i), 64'(bus.o_cfg_err), 64'd0);
         if (i == 1) begin
            set_cfg('0, '0, '0, '0, '0, 1'b0);
            bus.i_start = 1'b1;
         end
         if (i == 6) bus.i_abort = 1'b1;
         tick();
         bus.i_start = 1'b0;
      end
      bus.i_abort = 1'b0;
      chk("abort_flags", {61'd0, bus.o_busy, bus.o_k_update, bus.o_done}, 64'd0);
      chk("abort_k_hold", 64'(bus.o_k_out), 64'd30);
      tick();
      chk("abort_k_hold2", 64'(bus.o_k_out), 64'd30);

      // Invalid configs: zero step, then start above stop.
      set_cfg(32'd100, 32'd400, 32'd0, 16'd0, 11'd1, 1'b0);
      pulse_start();
      chk("err_step0", {62'd0, bus.o_cfg_err, bus.o_busy}, 64'b10);
      chk("err_step0_k", 64'(bus.o_k_out), 64'd30);
      tick();
      chk("err_step0_clr", 64'(bus.o_cfg_err), 64'd0);
      set_cfg(32'd500, 32'd400, 32'd1, 16'd0, 11'd1, 1'b0);
      pulse_start();
      chk("err_order", {61'd0, bus.o_cfg_err, bus.o_busy, bus.o_k_update}, 64'b100);
      tick();

      // Near-full-scale triangle: no wrap going up or down.
      set_cfg(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 16'd0, 11'h7FF, 1'b1);
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("ovf_k_out_%0d", i), 64'(bus.o_k_out), 64'(ovf_seq[i]));
         chk($sformatf("ovf_upd_%0d", i), 64'(bus.o_k_update), 64'd1);
         tick();
      end

      // Asynchronous reset mid-sweep, asserted away from the clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_k_out", 64'(bus.o_k_out), 64'd0);
      chk("arst_p_out", 64'(bus.o_p_out), 64'd0);
      chk("arst_flags", {60'd0, bus.o_k_update, bus.o_busy, bus.o_done, bus.o_cfg_err}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // start and abort together in IDLE: abort wins, nothing happens.
      set_cfg(32'd100, 32'd400, 32'd100, 16'd0, 11'd3, 1'b0);
      bus.i_abort = 1'b1;
      pulse_start();
      bus.i_abort = 1'b0;
      chk("sa_flags", {60'd0, bus.o_k_update, bus.o_busy, bus.o_done, bus.o_cfg_err}, 64'd0);
      chk("sa_k_out", 64'(bus.o_k_out), 64'd0);
      tick();
      chk("sa_idle", {62'd0, bus.o_busy, bus.o_k_update}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Sequencer that drives the frequency word and phase offset inputs of the DDS phase-accumulator block.
- Generates a linear frequency sweep from a start word to a stop word, with a programmable dwell time per step.
- Supports single-shot mode (up once, then done) and triangle mode (up/down continuously until abort).
- Sits between the register/config interface and the DDS core; outputs connect directly to the core's K and P inputs.

Parameters:
- KW, 32, frequency-word width (matches DDS K)
- PW, 11, phase-offset width (matches DDS P)
- DW, 16, dwell-counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle request to begin a sweep; sampled only in IDLE
- abort  in  1  stop sweep; honoured in any state
- cfg_k_start  in  KW  first frequency word
- cfg_k_stop  in  KW  last frequency word (must be >= cfg_k_start)
- cfg_k_step  in  KW  increment per step (must be nonzero)
- cfg_dwell  in  DW  extra hold cycles per frequency (hold = cfg_dwell+1 cycles)
- cfg_phase  in  PW  phase offset applied for the whole sweep
- cfg_mode  in  1  0 = single-shot, 1 = triangle continuous
- k_out  out  KW  frequency word to DDS
- p_out  out  PW  phase offset to DDS
- k_update  out  1  1-cycle strobe whenever k_out takes a new value (including re-application of an unchanged value)
- busy  out  1  high in UP or DOWN
- done  out  1  1-cycle pulse at single-shot completion
- cfg_err  out  1  1-cycle pulse when start is rejected

Behaviour:
- Clock and reset: clk is the clock; rst_n is asynchronous, active-low. All flops reset via rst_n.
- Reset values: k_out=0, p_out=0, k_update=0, busy=0, done=0, cfg_err=0, state=IDLE, dwell counter=0, captured config=0.
- States: IDLE, UP, DOWN.
- IDLE + start, config valid:
  - Capture all cfg_* into internal registers; later cfg changes have no effect until the next start.
  - Next cycle: k_out=cfg_k_start, p_out=cfg_phase, k_update=1, busy=1, state=UP.
  - Dwell counter loads cfg_dwell.
- IDLE + start, config invalid (cfg_k_step==0 or cfg_k_start>cfg_k_stop):
  - cfg_err=1 for one cycle; state stays IDLE; outputs unchanged.
- Dwell:
  - Counter decrements each cycle; expiry is the cycle the counter reads 0.
  - Each k_out value is therefore held cfg_dwell+1 cycles.
  - Counter reloads on every k_out application.
- UP, at expiry:
  - If k_out<stop: k_out = min(k_out+step, stop), computed at KW+1 bits (no wrap); k_update=1.
  - If k_out==stop and mode=0: state=IDLE, busy=0, done=1 for one cycle; k_out and p_out hold their last value.
  - If k_out==stop and mode=1: state=DOWN; k_out = max(k_out-step, start), computed without underflow; k_update=1.
- DOWN, at expiry:
  - If k_out>start: k_out = max(k_out-step, start); k_update=1.
  - If k_out==start: state=UP; k_out = min(k_out+step, stop); k_update=1.
- start==stop, mode=1: k_out stays constant; k_update pulses every dwell expiry; state toggles UP/DOWN.
- Abort, any state:
  - Next cycle state=IDLE, busy=0, k_update=0, done=0.
  - k_out and p_out hold their values; the DDS keeps running at the last frequency.
  - abort and start in the same cycle in IDLE: abort wins; start ignored, no cfg_err.
- start while busy: ignored, no cfg_err.
- Outputs are registered; k_update aligns with the cycle k_out changes.
- Latency: start to first k_update = 1 cycle.
- Reset mid-sweep: immediate return to reset values.

Test Plan:
- start, k_start=100, k_stop=400, step=100, dwell=2, mode=0 -> k_out 100,200,300,400, each held 3 cycles; 4 k_update strobes; done pulses 3 cycles after 400 appears; busy low the same cycle.
- k_start=0, k_stop=250, step=100, dwell=0, mode=0 -> k_out 0,100,200,250 on consecutive cycles (saturation at stop); then done.
- Triangle: start=10, stop=30, step=10, dwell=0, mode=1 -> k_out 10,20,30,20,10,20,30… each cycle; no done; assert abort -> busy=0 next cycle, k_out holds current value.
- Invalid config: step=0 -> cfg_err pulses 1 cycle, busy stays 0; then k_start=500, k_stop=400 -> cfg_err again.
- Overflow: k_start=0xFFFFFF00, k_stop=0xFFFFFFFF, step=0x80, mode=1 -> k_out FFFFFF00, FFFFFF80, FFFFFFFF, FFFFFF7F, FFFFFF00 (no wrap in either direction).
- Assert rst_n low mid-sweep, and separately start+abort together in IDLE -> after reset, all outputs are 0; for start+abort, state stays IDLE with no k_update and no cfg_err.
